// File: rtl/unary_decoder_if.sv
// Handshake bundle for unary_decoder.
//   Input side : in_valid/in_ready/in_code (sign at bit MAG_W, thermometer magnitude below).
//   Output side: out_valid/out_ready plus out_value (signed), out_count, out_malformed.
// Handshake rule (both sides): a transfer occurs on a rising clock edge where
// valid and ready are both high; the producer holds data stable while valid is
// high and ready is low.
//   master : the upstream/downstream environment (drives in_*, out_ready)
//   slave  : the decoder itself
interface unary_decoder_if #(
    parameter int MAG_W   = 32,
    parameter int CHUNK_W = 4
);
    localparam int OUT_W = $clog2(MAG_W + 1) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [MAG_W:0]     in_code;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_value;
    logic [OUT_W-2:0]   out_count;
    logic               out_malformed;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_value, out_count, out_malformed
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_value, out_count, out_malformed
    );
endinterface

// File: rtl/unary_decoder.sv
// Sequential sign-magnitude unary to two's-complement decoder.
// A word is latched in IDLE, its thermometer magnitude is scanned CHUNK_W bits
// per cycle in SCAN, and the result is presented in DONE until taken.
// Ports:
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   bus         : unary_decoder_if slave modport (input and output handshakes)
//   o_dbg_state : current FSM state (0 IDLE, 1 SCAN, 2 DONE)
module unary_decoder #(
    parameter int MAG_W   = 32,
    parameter int CHUNK_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    unary_decoder_if.slave    bus,
    output logic [1:0]        o_dbg_state
);
    localparam int OUT_W   = $clog2(MAG_W + 1) + 1;
    localparam int CNT_W   = OUT_W - 1;
    localparam int N_CHUNK = MAG_W / CHUNK_W;
    localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [MAG_W-1:0]   r_shift;
    logic               r_sign;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_chunk_idx;
    logic               r_seen_zero;
    logic               r_malformed;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_value;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_malformed;

    logic [CHUNK_W-1:0] w_chunk;
    logic [CNT_W-1:0]   w_pop;
    logic               w_chunk_bad;
    logic               w_chunk_has_zero;
    logic               w_zero_below;
    logic [OUT_W-1:0]   w_mag_ext;
    logic [OUT_W-1:0]   w_value;

    assign w_chunk = r_shift[CHUNK_W-1:0];

    // Popcount of the chunk and a contiguity check: walking up from the LSB,
    // any 1 after a 0 breaks the thermometer pattern inside this chunk.
    always_comb begin
        w_pop        = '0;
        w_chunk_bad  = 1'b0;
        w_zero_below = 1'b0;
        for (int i = 0; i < CHUNK_W; i++) begin
            w_pop = w_pop + {{(CNT_W-1){1'b0}}, w_chunk[i]};
            if (w_chunk[i] && w_zero_below) begin
                w_chunk_bad = 1'b1;
            end
            if (!w_chunk[i]) begin
                w_zero_below = 1'b1;
            end
        end
    end

    assign w_chunk_has_zero = ~&w_chunk;

    // Sign is applied to the final count; a zero count yields 0 either way.
    assign w_mag_ext = {1'b0, r_count};
    assign w_value   = r_sign ? (~w_mag_ext + {{(OUT_W-1){1'b0}}, 1'b1}) : w_mag_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_shift         <= '0;
            r_sign          <= 1'b0;
            r_count         <= '0;
            r_chunk_idx     <= '0;
            r_seen_zero     <= 1'b0;
            r_malformed     <= 1'b0;
            r_in_ready      <= 1'b1;
            r_out_valid     <= 1'b0;
            r_out_value     <= '0;
            r_out_count     <= '0;
            r_out_malformed <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign      <= bus.in_code[MAG_W];
                        r_shift     <= bus.in_code[MAG_W-1:0];
                        r_count     <= '0;
                        r_seen_zero <= 1'b0;
                        r_malformed <= 1'b0;
                        r_chunk_idx <= '0;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_count     <= r_count + w_pop;
                    // A 1 anywhere after a 0 has already been seen in a lower
                    // chunk is also a contiguity break.
                    r_malformed <= r_malformed | w_chunk_bad
                                   | (r_seen_zero & (|w_chunk));
                    r_seen_zero <= r_seen_zero | w_chunk_has_zero;
                    r_shift     <= r_shift >> CHUNK_W;
                    r_chunk_idx <= r_chunk_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (r_chunk_idx == IDX_W'(N_CHUNK - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes the accumulated result; the
                    // outputs then hold until the consumer takes them.
                    if (!r_out_valid) begin
                        r_out_count     <= r_count;
                        r_out_value     <= w_value;
                        r_out_malformed <= r_malformed;
                        r_out_valid     <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_value     = r_out_value;
    assign bus.out_count     = r_out_count;
    assign bus.out_malformed = r_out_malformed;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_unary_decoder.sv
module tb_unary_decoder;
    localparam int MAG_W   = 32;
    localparam int CHUNK_W = 4;
    localparam int OUT_W   = 7;
    localparam int LAT     = MAG_W / CHUNK_W + 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    unary_decoder_if #(.MAG_W(MAG_W), .CHUNK_W(CHUNK_W)) bus ();

    unary_decoder #(.MAG_W(MAG_W), .CHUNK_W(CHUNK_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    // Expected result packed as {malformed, count[5:0], value[6:0]}.
    logic [13:0] exp_q[$];
    int          acc_q[$];
    bit          busy       = 1'b0;
    bit          prev_valid = 1'b0;
    bit          hs_pending = 1'b0;
    logic [13:0] held;

    function automatic logic [13:0] model(input logic [MAG_W:0] code);
        int          cnt;
        int          val;
        logic [MAG_W:0] thermo;
        logic        bad;
        logic [OUT_W-1:0] v7;
        logic [5:0]  c6;
        cnt    = $countones(code[MAG_W-1:0]);
        val    = code[MAG_W] ? -cnt : cnt;
        thermo = (33'd1 << cnt) - 33'd1;
        bad    = (thermo != {1'b0, code[MAG_W-1:0]});
        v7     = val[OUT_W-1:0];
        c6     = cnt[5:0];
        return {bad, c6, v7};
    endfunction

    always @(negedge clk) begin
        logic [13:0] e;
        int          a;
        if (!rst_n) begin
            chk("rst_in_ready",  bus.in_ready, 1);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_outputs",   {bus.out_malformed, bus.out_count, bus.out_value}, 0);
            busy = 0; prev_valid = 0; hs_pending = 0;
            exp_q.delete(); acc_q.delete();
        end else begin
            chk("in_ready", bus.in_ready, !busy);
            if (hs_pending) chk("out_valid_drop", bus.out_valid, 0);
            hs_pending = 0;
            if (bus.out_valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        chk("value",     bus.out_value, e[6:0]);
                        chk("count",     bus.out_count, e[12:7]);
                        chk("malformed", bus.out_malformed, e[13]);
                        chk("latency",   edge_cnt - a, LAT);
                        held = {bus.out_malformed, bus.out_count, bus.out_value};
                    end
                end else begin
                    chk("hold", {bus.out_malformed, bus.out_count, bus.out_value}, held);
                end
            end
            prev_valid = bus.out_valid;
            // Events that take effect at the coming rising edge.
            if (bus.out_valid && bus.out_ready) begin
                busy = 0;
                hs_pending = 1;
            end else if (bus.in_valid && !busy) begin
                exp_q.push_back(model(bus.in_code));
                acc_q.push_back(edge_cnt + 1);
                busy = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic s, input logic [MAG_W-1:0] m);
        bit got;
        bus.in_valid = 1'b1;
        bus.in_code  = {s, m};
        got = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_code  = {1'($urandom_range(1)), 32'($urandom())};
    endtask

    task automatic wait_out();
        bit got;
        got = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic finish_xfer();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_code   = {1'b0, 32'h0000_01FF};
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("dbg_idle_in_reset", dbg_state, 0);
        rst_n = 1'b1;

        // Positive decode, presented since reset: accepted at first edge after release.
        send(1'b0, 32'h0000_01FF);
        wait_out();
        chk("pos9_value", bus.out_value, 7'd9);
        chk("pos9_count", bus.out_count, 6'd9);
        chk("pos9_mal",   bus.out_malformed, 0);
        finish_xfer();

        // Negative full scale.
        send(1'b1, 32'hFFFF_FFFF);
        wait_out();
        chk("neg32_value", bus.out_value, 7'b1100000);
        chk("neg32_count", bus.out_count, 6'd32);
        chk("neg32_mal",   bus.out_malformed, 0);
        finish_xfer();

        // Negative zero.
        send(1'b1, 32'h0000_0000);
        wait_out();
        chk("negzero_value", bus.out_value, 7'd0);
        chk("negzero_count", bus.out_count, 6'd0);
        finish_xfer();

        // Malformed, break spanning chunks.
        send(1'b0, 32'h0000_0105);
        wait_out();
        chk("mal_count", bus.out_count, 6'd3);
        chk("mal_value", bus.out_value, 7'd3);
        chk("mal_flag",  bus.out_malformed, 1);
        finish_xfer();

        // Backpressure.
        bus.out_ready = 1'b0;
        send(1'b1, 32'h0000_003F);
        wait_out();
        chk("bp_value", bus.out_value, 7'b1111010);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom_range(1));
            bus.in_code  = {1'($urandom_range(1)), 32'($urandom())};
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        finish_xfer();
        @(negedge clk);
        chk("bp_after_valid", bus.out_valid, 0);
        chk("bp_after_ready", bus.in_ready, 1);
        chk("bp_after_state", dbg_state, 0);

        // Reset mid-scan.
        send(1'b0, 32'h0000_0F0F);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", bus.in_ready, 1);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_state", dbg_state, 0);
        repeat (12) @(posedge clk);
        #1;
        send(1'b0, 32'h0000_000F);
        wait_out();
        chk("post_rst_value", bus.out_value, 7'd4);
        chk("post_rst_count", bus.out_count, 6'd4);
        finish_xfer();

        repeat (5) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
